player_motion_ctrl: RTL and testbench

// Parametrised successor to the per-frame player updater. On each start pulse it

---
 rtl/player_motion_ctrl_pkg.sv | 44 ++++
 rtl/player_motion_ctrl_if.sv | 14 +
 rtl/pmc_axis_step.sv | 38 +++
 rtl/player_motion_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_player_motion_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/player_motion_ctrl_pkg.sv
// Shared types and constants for the player motion controller.
package player_motion_ctrl_pkg;

    // Update sequencer states.
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_CALC     = 4'd1,
        S_PROBE_XY = 4'd2,
        S_WAIT_XY  = 4'd3,
        S_PROBE_X  = 4'd4,
        S_WAIT_X   = 4'd5,
        S_PROBE_Y  = 4'd6,
        S_WAIT_Y   = 4'd7,
        S_COMMIT   = 4'd8,
        S_DONE     = 4'd9
    } state_e;

    // Resolved move intent after cancelling opposing keys.
    typedef enum logic [1:0] {
        MOVE_NONE = 2'd0,
        MOVE_FWD  = 2'd1,
        MOVE_BWD  = 2'd2
    } move_e;

    // Map cell code for walkable space; every other code is solid.
    localparam logic [2:0] GRID_EMPTY = 3'b000;

    // Bit positions inside the sampled key vector.
    localparam int KEY_RIGHT = 0;
    localparam int KEY_LEFT  = 1;
    localparam int KEY_FWD   = 2;
    localparam int KEY_BWD   = 3;
    localparam int KEY_W     = 4;

    // Forward and backward held together cancel out.
    function automatic move_e resolve_move(input logic [KEY_W-1:0] keys);
        case ({keys[KEY_BWD], keys[KEY_FWD]})
            2'b01:   return MOVE_FWD;
            2'b10:   return MOVE_BWD;
            default: return MOVE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/player_motion_ctrl_if.sv
// Map lookup port: the controller issues a cell request, the map RAM answers
// with the cell type a fixed number of cycles later.
interface player_motion_ctrl_if #(
    parameter int GX_W = 6,
    parameter int GY_W = 5
);
    logic            grid_req;
    logic [GX_W-1:0] grid_x;
    logic [GY_W-1:0] grid_y;
    logic [2:0]      grid_out;

    modport master (output grid_req, output grid_x, output grid_y, input grid_out);
    modport slave  (input grid_req, input grid_x, input grid_y, output grid_out);
endinterface

// File: rtl/pmc_axis_step.sv
// One axis of the motion step: applies the signed, scaled direction component
// to an unsigned position and flags results that leave the position range.
module pmc_axis_step
    import player_motion_ctrl_pkg::*;
#(
    parameter int POS_W      = 15,
    parameter int DIR_W      = 15,
    parameter int MOVE_SHIFT = 2
) (
    input  logic [POS_W-1:0]        pos,
    input  logic signed [DIR_W-1:0] dir,
    input  move_e                   move,
    output logic [POS_W-1:0]        cand,
    output logic                    ovf,
    output logic                    moving
);
    // Wide enough that neither the position nor the negated displacement can wrap.
    localparam int SUM_W = ((POS_W > DIR_W) ? POS_W : DIR_W) + 2;

    logic signed [DIR_W-1:0] dir_sh;
    logic signed [DIR_W:0]   disp;
    logic signed [SUM_W-1:0] sum;

    // Signed add, then range-check before truncating back to position width.
    always_comb begin
        dir_sh = dir >>> MOVE_SHIFT;
        case (move)
            MOVE_FWD: disp = {dir_sh[DIR_W-1], dir_sh};
            MOVE_BWD: disp = -{dir_sh[DIR_W-1], dir_sh};
            default:  disp = '0;
        endcase
        sum    = SUM_W'(signed'({1'b0, pos})) + SUM_W'(disp);
        cand   = sum[POS_W-1:0];
        ovf    = sum[SUM_W-1] | (|sum[SUM_W-2:POS_W]);
        moving = (disp != '0);
    end

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-frame player pose updater: applies turn/move intent on each start pulse
// and commits only motion whose destination cell is empty, sliding along X
// then Y when the diagonal destination is blocked.
module player_motion_ctrl
    import player_motion_ctrl_pkg::*;
#(
    parameter int POS_X_W    = 15,
    parameter int POS_Y_W    = 14,
    parameter int ANGLE_W    = 8,
    parameter int DIR_W      = 15,
    parameter int CELL_SHIFT = 9,
    parameter int TURN_STEP  = 10,
    parameter int MOVE_SHIFT = 2,
    parameter int GRID_LAT   = 1
) (
    input  logic                    clock,
    input  logic                    reset,        // asynchronous, active low
    input  logic                    start,
    output logic                    done,
    output logic                    busy,
    input  logic                    turn_right,
    input  logic                    turn_left,
    input  logic                    move_forward,
    input  logic                    move_backward,
    input  logic [POS_X_W-1:0]      cur_pos_x,
    input  logic [POS_Y_W-1:0]      cur_pos_y,
    input  logic [ANGLE_W-1:0]      cur_angle,
    input  logic signed [DIR_W-1:0] dir_x,
    input  logic signed [DIR_W-1:0] dir_y,
    output logic [POS_X_W-1:0]      next_pos_x,
    output logic [POS_Y_W-1:0]      next_pos_y,
    output logic [ANGLE_W-1:0]      next_angle,
    player_motion_ctrl_if.master    grid
);
    localparam int GX_W  = POS_X_W - CELL_SHIFT;
    localparam int GY_W  = POS_Y_W - CELL_SHIFT;
    localparam int CNT_W = $clog2(GRID_LAT + 1);

    state_e                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    req_q, req_d;
    logic [GX_W-1:0]         gx_q, gx_d;
    logic [GY_W-1:0]         gy_q, gy_d;
    logic [POS_X_W-1:0]      next_x_q, next_x_d;
    logic [POS_Y_W-1:0]      next_y_q, next_y_d;
    logic [ANGLE_W-1:0]      next_a_q, next_a_d;
    logic [POS_X_W-1:0]      pos_x_q, pos_x_d;
    logic [POS_Y_W-1:0]      pos_y_q, pos_y_d;
    logic [ANGLE_W-1:0]      ang_q, ang_d;
    logic signed [DIR_W-1:0] dir_x_q, dir_x_d;
    logic signed [DIR_W-1:0] dir_y_q, dir_y_d;
    logic [KEY_W-1:0]        keys_q, keys_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    take_x_q, take_x_d;
    logic                    take_y_q, take_y_d;

    move_e                   move;
    logic [POS_X_W-1:0]      cand_x;
    logic [POS_Y_W-1:0]      cand_y;
    logic                    ovf_x, ovf_y, mov_x, mov_y;
    logic [ANGLE_W-1:0]      ang_turn;
    logic                    wait_done, cell_empty;

    assign move = resolve_move(keys_q);

    pmc_axis_step #(.POS_W(POS_X_W), .DIR_W(DIR_W), .MOVE_SHIFT(MOVE_SHIFT)) u_step_x (
        .pos(pos_x_q), .dir(dir_x_q), .move(move),
        .cand(cand_x), .ovf(ovf_x), .moving(mov_x)
    );

    pmc_axis_step #(.POS_W(POS_Y_W), .DIR_W(DIR_W), .MOVE_SHIFT(MOVE_SHIFT)) u_step_y (
        .pos(pos_y_q), .dir(dir_y_q), .move(move),
        .cand(cand_y), .ovf(ovf_y), .moving(mov_y)
    );

    // Turned angle; opposing turn keys cancel and the sum wraps modulo a full turn.
    always_comb begin
        case ({keys_q[KEY_LEFT], keys_q[KEY_RIGHT]})
            2'b01:   ang_turn = ang_q + ANGLE_W'(TURN_STEP);
            2'b10:   ang_turn = ang_q - ANGLE_W'(TURN_STEP);
            default: ang_turn = ang_q;
        endcase
    end

    assign wait_done  = (cnt_q == '0);
    assign cell_empty = (grid.grid_out == GRID_EMPTY);

    // Next-state and next-output logic for the whole update sequence.
    always_comb begin
        // NOTE: every *_d starts from its held value so no path through the case infers a latch.
        state_d  = state_q;
        done_d   = 1'b0;
        req_d    = 1'b0;
        gx_d     = gx_q;
        gy_d     = gy_q;
        next_x_d = next_x_q;
        next_y_d = next_y_q;
        next_a_d = next_a_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        ang_d    = ang_q;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        keys_d   = keys_q;
        cnt_d    = cnt_q;
        take_x_d = take_x_q;
        take_y_d = take_y_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pos_x_d           = cur_pos_x;
                    pos_y_d           = cur_pos_y;
                    ang_d             = cur_angle;
                    dir_x_d           = dir_x;
                    dir_y_d           = dir_y;
                    keys_d[KEY_RIGHT] = turn_right;
                    keys_d[KEY_LEFT]  = turn_left;
                    keys_d[KEY_FWD]   = move_forward;
                    keys_d[KEY_BWD]   = move_backward;
                    state_d           = S_CALC;
                end
            end
            S_CALC: begin
                take_x_d = 1'b0;
                take_y_d = 1'b0;
                state_d  = (mov_x || mov_y) ? S_PROBE_XY : S_COMMIT;
            end
            S_PROBE_XY: begin
                if (ovf_x || ovf_y) begin
                    state_d = S_PROBE_X;
                end else begin
                    req_d   = 1'b1;
                    gx_d    = cand_x[POS_X_W-1:CELL_SHIFT];
                    gy_d    = cand_y[POS_Y_W-1:CELL_SHIFT];
                    cnt_d   = CNT_W'(GRID_LAT);
                    state_d = S_WAIT_XY;
                end
            end
            S_WAIT_XY: begin
                if (!wait_done) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (cell_empty) begin
                    take_x_d = 1'b1;
                    take_y_d = 1'b1;
                    state_d  = S_COMMIT;
                end else begin
                    state_d = S_PROBE_X;
                end
            end
            S_PROBE_X: begin
                if (ovf_x) begin
                    state_d = S_PROBE_Y;
                end else begin
                    req_d   = 1'b1;
                    gx_d    = cand_x[POS_X_W-1:CELL_SHIFT];
                    gy_d    = pos_y_q[POS_Y_W-1:CELL_SHIFT];
                    cnt_d   = CNT_W'(GRID_LAT);
                    state_d = S_WAIT_X;
                end
            end
            S_WAIT_X: begin
                if (!wait_done) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (cell_empty) begin
                    take_x_d = 1'b1;
                    state_d  = S_COMMIT;
                end else begin
                    state_d = S_PROBE_Y;
                end
            end
            S_PROBE_Y: begin
                if (ovf_y) begin
                    state_d = S_COMMIT;
                end else begin
                    req_d   = 1'b1;
                    gx_d    = pos_x_q[POS_X_W-1:CELL_SHIFT];
                    gy_d    = cand_y[POS_Y_W-1:CELL_SHIFT];
                    cnt_d   = CNT_W'(GRID_LAT);
                    state_d = S_WAIT_Y;
                end
            end
            S_WAIT_Y: begin
                if (!wait_done) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    take_y_d = cell_empty;
                    state_d  = S_COMMIT;
                end
            end
            S_COMMIT: begin
                next_x_d = take_x_q ? cand_x : pos_x_q;
                next_y_d = take_y_q ? cand_y : pos_y_q;
                next_a_d = ang_turn;
                done_d   = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset abandons any update in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            req_q    <= 1'b0;
            gx_q     <= '0;
            gy_q     <= '0;
            next_x_q <= '0;
            next_y_q <= '0;
            next_a_q <= '0;
            pos_x_q  <= '0;
            pos_y_q  <= '0;
            ang_q    <= '0;
            dir_x_q  <= '0;
            dir_y_q  <= '0;
            keys_q   <= '0;
            cnt_q    <= '0;
            take_x_q <= 1'b0;
            take_y_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop sees the pre-edge value of every other flop.
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            req_q    <= req_d;
            gx_q     <= gx_d;
            gy_q     <= gy_d;
            next_x_q <= next_x_d;
            next_y_q <= next_y_d;
            next_a_q <= next_a_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            ang_q    <= ang_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
            keys_q   <= keys_d;
            cnt_q    <= cnt_d;
            take_x_q <= take_x_d;
            take_y_q <= take_y_d;
        end
    end

    assign done          = done_q;
    assign busy          = busy_q;
    assign next_pos_x    = next_x_q;
    assign next_pos_y    = next_y_q;
    assign next_angle    = next_a_q;
    assign grid.grid_req = req_q;
    assign grid.grid_x   = gx_q;
    assign grid.grid_y   = gy_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl: one instance with a 1-cycle map
// latency and one with a 3-cycle map latency run the same vectors side by side.
module tb_player_motion_ctrl;

    localparam logic [3:0] K_R = 4'b0001;
    localparam logic [3:0] K_L = 4'b0010;
    localparam logic [3:0] K_F = 4'b0100;
    localparam logic [3:0] K_B = 4'b1000;

    typedef struct {
        string      name;
        logic [3:0] keys;      // {bwd, fwd, left, right}
        int         px, py, ang, dxv, dyv;
        int         c0, c1, c2; // solid cells as gx*32+gy, -1 = unused
        int         ex, ey, ea; // expected committed pose
        int         ereqs;      // expected number of grid requests
        int         egx, egy;   // expected cell of the last request
        bit         chk_lat;    // latency follows 3 + reqs*(2+lat)
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic tr = 1'b0, tl = 1'b0, mf = 1'b0, mb = 1'b0;
    logic [14:0] cpx = '0;
    logic [13:0] cpy = '0;
    logic [7:0]  cang = '0;
    logic signed [14:0] dirx = '0, diry = '0;

    logic        done1, busy1, done3, busy3;
    logic [14:0] nx1, nx3;
    logic [13:0] ny1, ny3;
    logic [7:0]  na1, na3;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    bit solid [64][32];

    player_motion_ctrl_if #(.GX_W(6), .GY_W(5)) gif1 ();
    player_motion_ctrl_if #(.GX_W(6), .GY_W(5)) gif3 ();

    player_motion_ctrl #(.GRID_LAT(1)) u_l1 (
        .clock(clk), .reset(rst_n), .start(start), .done(done1), .busy(busy1),
        .turn_right(tr), .turn_left(tl), .move_forward(mf), .move_backward(mb),
        .cur_pos_x(cpx), .cur_pos_y(cpy), .cur_angle(cang), .dir_x(dirx), .dir_y(diry),
        .next_pos_x(nx1), .next_pos_y(ny1), .next_angle(na1), .grid(gif1.master)
    );

    player_motion_ctrl #(.GRID_LAT(3)) u_l3 (
        .clock(clk), .reset(rst_n), .start(start), .done(done3), .busy(busy3),
        .turn_right(tr), .turn_left(tl), .move_forward(mf), .move_backward(mb),
        .cur_pos_x(cpx), .cur_pos_y(cpy), .cur_angle(cang), .dir_x(dirx), .dir_y(diry),
        .next_pos_x(nx3), .next_pos_y(ny3), .next_angle(na3), .grid(gif3.master)
    );

    always #5 clk = ~clk;

    // Map RAM models: the cell answer is valid only in the cycle exactly
    // LAT cycles after the request cycle; any other cycle reads as solid.
    int age1 = -1, age3 = -1;
    int req_cnt1 = 0, req_cnt3 = 0;
    logic [5:0] lgx1 = '0, lgx3 = '0;
    logic [4:0] lgy1 = '0, lgy3 = '0;

    function automatic logic [2:0] cell_val(input logic [5:0] x, input logic [4:0] y);
        return solid[x][y] ? 3'b011 : 3'b000;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age1 <= -1;
        end else if (gif1.grid_req) begin
            age1     <= 1;
            lgx1     <= gif1.grid_x;
            lgy1     <= gif1.grid_y;
            req_cnt1 <= req_cnt1 + 1;
        end else if (age1 > 0) begin
            age1 <= age1 + 1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age3 <= -1;
        end else if (gif3.grid_req) begin
            age3     <= 1;
            lgx3     <= gif3.grid_x;
            lgy3     <= gif3.grid_y;
            req_cnt3 <= req_cnt3 + 1;
        end else if (age3 > 0) begin
            age3 <= age3 + 1;
        end
    end

    assign gif1.grid_out = (age1 == 1) ? cell_val(lgx1, lgy1) : 3'b110;
    assign gif3.grid_out = (age3 == 3) ? cell_val(lgx3, lgy3) : 3'b110;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [3:0] keys,
                           input int px, input int py, input int ang, input int dxv, input int dyv,
                           input int c0, input int c1, input int c2,
                           input int ex, input int ey, input int ea,
                           input int ereqs, input int egx, input int egy, input bit chk_lat);
        vec_t v;
        v.name = name; v.keys = keys; v.px = px; v.py = py; v.ang = ang;
        v.dxv = dxv; v.dyv = dyv; v.c0 = c0; v.c1 = c1; v.c2 = c2;
        v.ex = ex; v.ey = ey; v.ea = ea; v.ereqs = ereqs; v.egx = egx; v.egy = egy;
        v.chk_lat = chk_lat;
        vecs.push_back(v);
    endtask

    task automatic set_map(input vec_t v);
        for (int x = 0; x < 64; x++)
            for (int y = 0; y < 32; y++)
                solid[x][y] = 1'b0;
        if (v.c0 >= 0) solid[v.c0 / 32][v.c0 % 32] = 1'b1;
        if (v.c1 >= 0) solid[v.c1 / 32][v.c1 % 32] = 1'b1;
        if (v.c2 >= 0) solid[v.c2 / 32][v.c2 % 32] = 1'b1;
    endtask

    task automatic drive_inputs(input vec_t v);
        {mb, mf, tl, tr} = v.keys;
        cpx  = 15'(v.px);
        cpy  = 14'(v.py);
        cang = 8'(v.ang);
        dirx = 15'(v.dxv);
        diry = 15'(v.dyv);
    endtask

    task automatic check_dut(input string tag, input vec_t v, input int lat_cfg,
                             input int lat, input int dn, input int reqs,
                             input logic [5:0] lgx, input logic [4:0] lgy,
                             input logic [14:0] nx, input logic [13:0] ny, input logic [7:0] na);
        check({v.name, tag, " done_seen"}, 64'(lat >= 0), 64'd1);
        check({v.name, tag, " done_pulses"}, 64'(dn), 64'd1);
        check({v.name, tag, " next_x"}, 64'(nx), 64'(v.ex));
        check({v.name, tag, " next_y"}, 64'(ny), 64'(v.ey));
        check({v.name, tag, " next_angle"}, 64'(na), 64'(v.ea));
        check({v.name, tag, " grid_reqs"}, 64'(reqs), 64'(v.ereqs));
        if (v.ereqs > 0) begin
            check({v.name, tag, " last_grid_x"}, 64'(lgx), 64'(v.egx));
            check({v.name, tag, " last_grid_y"}, 64'(lgy), 64'(v.egy));
        end
        if (v.chk_lat)
            check({v.name, tag, " latency"}, 64'(lat), 64'(3 + v.ereqs * (2 + lat_cfg)));
    endtask

    // One update on both instances; restart_cyc > 1 pulses a second start
    // (with different inputs) in that cycle, which must be ignored.
    task automatic run_update(input vec_t v, input int restart_cyc);
        int lat1, lat3, dn1, dn3, r1, r3;
        set_map(v);
        @(negedge clk);
        drive_inputs(v);
        r1 = req_cnt1;
        r3 = req_cnt3;
        start = 1'b1;
        lat1 = -1; lat3 = -1; dn1 = 0; dn3 = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) start = 1'b0;
            if (c == restart_cyc) begin
                start = 1'b1;
                {mb, mf, tl, tr} = K_F | K_R;
                cpx = 15'd20000; cpy = 14'd300; cang = 8'd7; dirx = 15'sd4096; diry = 15'sd0;
            end else if (c == restart_cyc + 1) begin
                start = 1'b0;
            end
            if (done1) begin dn1++; if (lat1 < 0) lat1 = c; end
            if (done3) begin dn3++; if (lat3 < 0) lat3 = c; end
        end
        check_dut("/L1", v, 1, lat1, dn1, req_cnt1 - r1, lgx1, lgy1, nx1, ny1, na1);
        check_dut("/L3", v, 3, lat3, dn3, req_cnt3 - r3, lgx3, lgy3, nx3, ny3, na3);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " L1 done"},   64'(done1), 64'd0);
        check({tag, " L1 busy"},   64'(busy1), 64'd0);
        check({tag, " L1 req"},    64'(gif1.grid_req), 64'd0);
        check({tag, " L1 grid_x"}, 64'(gif1.grid_x), 64'd0);
        check({tag, " L1 grid_y"}, 64'(gif1.grid_y), 64'd0);
        check({tag, " L1 next"},   64'({nx1, ny1, na1}), 64'd0);
        check({tag, " L3 done"},   64'(done3), 64'd0);
        check({tag, " L3 busy"},   64'(busy3), 64'd0);
        check({tag, " L3 req"},    64'(gif3.grid_req), 64'd0);
        check({tag, " L3 grid"},   64'({gif3.grid_x, gif3.grid_y}), 64'd0);
        check({tag, " L3 next"},   64'({nx3, ny3, na3}), 64'd0);
    endtask

    initial begin
        int dn;

        //       name           keys       px     py    ang  dir_x  dir_y   solid cells    ex    ey    ea reqs gx gy lat
        add_vec("idle",        4'b0000,   1000,  1000,  40,  4096,     0, -1, -1, -1,  1000, 1000,  40, 0,  0, 0, 1);
        add_vec("wrap_right",  K_R,       1000,  1000, 250,  4096,     0, -1, -1, -1,  1000, 1000,   4, 0,  0, 0, 1);
        add_vec("wrap_left",   K_L,       1000,  1000,   5,  4096,     0, -1, -1, -1,  1000, 1000, 251, 0,  0, 0, 1);
        add_vec("turn_cancel", K_R | K_L, 1000,  1000, 100,  4096,     0, -1, -1, -1,  1000, 1000, 100, 0,  0, 0, 1);
        add_vec("fwd_x",       K_F,       1000,  1000,  40,  4096,     0, -1, -1, -1,  2024, 1000,  40, 1,  3, 1, 1);
        add_vec("fwd_turn",    K_F | K_R, 2024,  1000,  40,  4096,     0, -1, -1, -1,  3048, 1000,  50, 1,  5, 1, 1);
        add_vec("bwd_x",       K_B,       3000,  1000,   0,  4096,     0, -1, -1, -1,  1976, 1000,   0, 1,  3, 1, 1);
        add_vec("move_cancel", K_F|K_B|K_R, 1000, 1000, 60,  4096,     0, -1, -1, -1,  1000, 1000,  70, 0,  0, 0, 1);
        add_vec("zero_disp",   K_F,       1000,  1000,  60,     3,     2, -1, -1, -1,  1000, 1000,  60, 0,  0, 0, 1);
        add_vec("ashr",        K_F,       1000,  1000,  60,    -3,     7, -1, -1, -1,   999, 1001,  60, 1,  1, 1, 1);
        add_vec("slide_x",     K_F,       1000,  3000,  40,  2048, -2048, 68, -1, -1,  1512, 3000,  40, 2,  2, 5, 1);
        add_vec("slide_y",     K_F,       1000,  3000,  40,  2048, -2048, 68, 69, -1,  1000, 2488,  40, 3,  1, 4, 1);
        add_vec("blocked",     K_F | K_R, 1000,  3000,  40,  2048, -2048, 68, 69, 36,  1000, 3000,  50, 3,  1, 4, 1);
        add_vec("x_underflow", K_B,         10,  3000,  40,  4096,  2048, -1, -1, -1,    10, 2488,  40, 1,  0, 4, 0);
        add_vec("y_overflow",  K_F,       5000, 16000,  40,     0,  4096, -1, -1, -1,  5000, 16000, 40, 1,  9, 31, 0);

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_update(vecs[i], 0);

        // Second start while busy (mid lookup) and in the done cycle: both ignored.
        run_update(vecs[10], 4);
        run_update(vecs[0], 3);

        // Reset while waiting on the diagonal lookup: abort with no commit and no done.
        set_map(vecs[4]);
        @(negedge clk);
        drive_inputs(vecs[4]);
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        check("midreset L1 busy", 64'(busy1), 64'd1);
        @(posedge clk); #1;
        check("midreset L1 in_wait_req", 64'(gif1.grid_req), 64'd1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done1 || done3) dn++;
        end
        check("midreset no_done", 64'(dn), 64'd0);
        check("midreset next_held_zero", 64'({nx1, ny1, na1, nx3, ny3, na3}), 64'd0);

        // Normal operation after the abort.
        run_update(vecs[4], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
